// File: rtl/cs_accum_pkg.sv
// Shared helpers for the carry-save sum accumulator: frame counter sizing and the
// offset that turns frame_len into the index of the last pair in a frame.
package cs_accum_pkg;

  // The last pair of a frame is seen when the counter reaches frame_len minus this.
  localparam int unsigned FRAME_LAST_OFFSET = 1;

  // Ceiling log2, clamped to at least one bit so frame_len = 1 still has a counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cs_resolve_reg.sv
// Stage 1: carry-propagate add of the carry-save pair into a one-entry register slice
// with valid/ready flow control toward the accumulator.
module cs_resolve_reg #(
  parameter int unsigned input_width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [input_width-1:0] in_out0,
  input  logic [input_width-1:0] in_out1,
  input  logic                   take,
  output logic                   p_valid,
  output logic [input_width-1:0] p_sum
);

  logic [input_width-1:0] sum;

  // Modular unsigned add, matching the tree's own wrap-around semantics.
  assign sum      = in_out0 + in_out1;
  assign in_ready = !clr && (!p_valid || take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_sum   <= '0;
    end else if (clr) begin
      p_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      p_valid <= 1'b1;
      p_sum   <= sum;
    end else if (take) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cs_sum_accum.sv
// Resolves carry-save pairs to binary sums and accumulates frame_len of them into a
// frame result presented on a valid/ready port, with a sticky overflow flag.
module cs_sum_accum
  import cs_accum_pkg::*;
#(
  parameter int unsigned input_width = 8,
  parameter int unsigned acc_width   = 16,
  parameter int unsigned frame_len   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [input_width-1:0] in_out0,
  input  logic [input_width-1:0] in_out1,
  output logic                   acc_valid,
  input  logic                   acc_ready,
  output logic [acc_width-1:0]   acc_data,
  output logic                   acc_ovf
);

  localparam int unsigned      CNT_W = clog2_min1(frame_len);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(frame_len - FRAME_LAST_OFFSET);

  logic                   p_valid;
  logic [input_width-1:0] p_sum;
  logic                   take;
  logic [acc_width-1:0]   acc_reg;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf_run;
  logic [acc_width:0]     sum_ext;
  logic [acc_width-1:0]   acc_next;
  logic                   carry;

  // clr freezes stage 2 for its cycle, so a clear never races a frame completion.
  assign take     = p_valid && (!acc_valid || acc_ready) && !clr;
  assign sum_ext  = {1'b0, acc_reg} + {{(acc_width + 1 - input_width){1'b0}}, p_sum};
  assign acc_next = sum_ext[acc_width-1:0];
  assign carry    = sum_ext[acc_width];

  cs_resolve_reg #(
    .input_width(input_width)
  ) u_resolve (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_out0 (in_out0),
    .in_out1 (in_out1),
    .take    (take),
    .p_valid (p_valid),
    .p_sum   (p_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      cnt       <= '0;
      ovf_run   <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      // NOTE: the last non-blocking assignment in the block wins, so a frame that
      // completes in the same cycle the sink drains keeps acc_valid high.
      if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
      if (clr) begin
        acc_reg <= '0;
        cnt     <= '0;
        ovf_run <= 1'b0;
      end else if (take) begin
        if (cnt == LAST) begin
          acc_data  <= acc_next;
          acc_ovf   <= ovf_run | carry;
          acc_valid <= 1'b1;
          acc_reg   <= '0;
          cnt       <= '0;
          ovf_run   <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          cnt     <= cnt + CNT_W'(1);
          ovf_run <= ovf_run | carry;
        end
      end
    end
  end

endmodule
